// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - card geometry, widths and fill FSM state type
package card_pkg;

  localparam int CARD_W  = 16;
  localparam int CARD_H  = 32;
  localparam int ADDR_W  = 9;
  localparam int COLOR_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/card_addr_gen.sv
// rtl/card_addr_gen.sv - card window check and card memory address from screen position
module card_addr_gen
  import card_pkg::*;
(
  input  logic [7:0]        pix_x,
  input  logic [7:0]        pix_y,
  input  logic [7:0]        card_x,
  input  logic [7:0]        card_y,
  output logic              in_window,
  output logic [ADDR_W-1:0] addr
);

  logic [8:0] dx;
  logic [8:0] dy;

  // 9-bit subtraction: a pixel left of/above the card underflows to a large value and clips
  always_comb begin
    dx = {1'b0, pix_x} - {1'b0, card_x};
    dy = {1'b0, pix_y} - {1'b0, card_y};
  end

  assign in_window = (dx <= 9'(CARD_W - 1)) && (dy <= 9'(CARD_H - 1));
  assign addr      = {dy[4:0], dx[3:0]};

endmodule

// File: rtl/card_mem_sched.sv
// rtl/card_mem_sched.sv - card memory scheduler: display reads, host writes, optional fill (CARD_SCHED_FILL_EN)
module card_mem_sched
  import card_pkg::*;
#(
  parameter logic [COLOR_W-1:0] TRANSP_CODE = 3'b111
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pix_valid_in,
  input  logic [7:0]         pix_x,
  input  logic [7:0]         pix_y,
  input  logic [7:0]         card_x,
  input  logic [7:0]         card_y,
  output logic               pix_valid_out,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_opaque,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ack,
  input  logic               fill_start,
  input  logic [COLOR_W-1:0] fill_color,
  output logic               fill_busy,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [COLOR_W-1:0] mem_wdata
);

  logic               in_window;
  logic               s1_valid_q;
  logic               s1_inwin_q;
  logic               out_valid_q;
  logic [COLOR_W-1:0] out_color_q;
  logic               out_opaque_q;
  logic               wr_ack_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_waddr_q;
  logic [COLOR_W-1:0] mem_wdata_q;
  logic               host_grant;
  logic               fill_grant;
  logic [ADDR_W-1:0]  fill_addr;
  logic [COLOR_W-1:0] fill_wdata;

  card_addr_gen u_addr_gen (
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .card_x    (card_x),
    .card_y    (card_y),
    .in_window (in_window),
    .addr      (mem_raddr)
  );

  // Display pipeline: stage 1 waits for the registered memory read, stage 2 forms the pixel
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_inwin_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_color_q  <= '0;
      out_opaque_q <= 1'b0;
    end else begin
      s1_valid_q  <= pix_valid_in;
      s1_inwin_q  <= in_window;
      out_valid_q <= s1_valid_q;
      if (s1_valid_q && s1_inwin_q) begin
        out_color_q  <= mem_rdata;
        out_opaque_q <= (mem_rdata != TRANSP_CODE);
      end else begin
        out_color_q  <= '0;
        out_opaque_q <= 1'b0;
      end
    end
  end

  // Host write goes only into display-idle cycles, and never in the cycle its previous ack shows
  assign host_grant = wr_req && !pix_valid_in && !wr_ack_q;

`ifdef CARD_SCHED_FILL_EN
  fill_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [COLOR_W-1:0] color_q, color_d;

  // Fill state, address counter and latched colour
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end

  // Fill next state: writes only in cycles left over by the display and the host
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    color_d    = color_q;
    fill_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          color_d = fill_color;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (!pix_valid_in && !host_grant) begin
          fill_grant = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_busy  = (state_q == FILL);
  assign fill_addr  = cnt_q;
  assign fill_wdata = color_q;
`else
  logic unused_fill;

  assign unused_fill = ^{fill_start, fill_color};
  assign fill_grant  = 1'b0;
  assign fill_busy   = 1'b0;
  assign fill_addr   = '0;
  assign fill_wdata  = '0;
`endif

  // Registered write port; host beats fill when both want the same cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ack_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      wr_ack_q <= host_grant;
      mem_we_q <= host_grant || fill_grant;
      if (host_grant) begin
        mem_waddr_q <= wr_addr;
        mem_wdata_q <= wr_data;
      end else if (fill_grant) begin
        mem_waddr_q <= fill_addr;
        mem_wdata_q <= fill_wdata;
      end
    end
  end

  assign pix_valid_out = out_valid_q;
  assign pix_color     = out_color_q;
  assign pix_opaque    = out_opaque_q;
  assign wr_ack        = wr_ack_q;
  assign mem_we        = mem_we_q;
  assign mem_waddr     = mem_waddr_q;
  assign mem_wdata     = mem_wdata_q;

endmodule
